rhd_miso_capture: RTL

Parametrised multi-port MISO capture engine for the RHD acquisition front end. It sits between the SPI master (which drives CS/SCLK/MOSI) and the per-port data sinks, deserialising N_PORTS MISO lines in parallel. Each port has its own programmable sample delay to absorb cable and headstage round-trip skew. An optional DDR mode captures the second word that dual-die RHD parts drive on the SCLK falling edge.

---
 rtl/rhd_pkg.sv | 27 ++
 rtl/rhd_miso_port.sv | 62 ++++++
 rtl/rhd_miso_capture.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rhd_pkg.sv
// rhd_pkg
//   Shared definitions for the RHD MISO capture engine: word size, the
//   default history depth, channel tag width, the capture FSM state encoding
//   and the record carried through the strobe alignment pipeline.
package rhd_pkg;

    localparam int WORD_BITS     = 16;
    localparam int MAX_DELAY_DEF = 64;
    localparam int CHANNEL_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_e;

    // One alignment-pipeline stage: every strobe and frame attribute travels
    // together so that all of them see the same fixed latency.
    typedef struct packed {
        logic                 frame;
        logic                 rise;
        logic                 fall;
        logic                 ddr;
        logic [CHANNEL_W-1:0] chan;
    } strobe_t;

endpackage

// File: rtl/rhd_miso_port.sv
// rhd_miso_port
//   One MISO lane: sample history, per-port delay tap with clamp, and the
//   rising-edge (sr_a) / falling-edge (sr_b) shift registers.
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     miso_i                  raw MISO line
//     delay_i                 sample delay in clk cycles (values > MAX_DELAY-1 clamp)
//     shift_a_i / shift_b_i   shift the selected sample into sr_a / sr_b
//     clear_i                 zero both shift registers (frame restart)
//     nxt_a_o / nxt_b_o       value sr_a / sr_b takes if this cycle's shift
//                             completes the word (before any clear)
module rhd_miso_port
    import rhd_pkg::*;
#(
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DELAY_W   = $clog2(MAX_DELAY)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 miso_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic                 shift_a_i,
    input  logic                 shift_b_i,
    input  logic                 clear_i,
    output logic [WORD_BITS-1:0] nxt_a_o,
    output logic [WORD_BITS-1:0] nxt_b_o
);

    localparam int L = MAX_DELAY - 1;

    logic [L-1:0]         hist_q;
    logic [L:0]           tap;
    logic [DELAY_W-1:0]   dly_c;
    logic [DELAY_W-1:0]   sel;
    logic                 sample;
    logic [WORD_BITS-1:0] sr_a_q;
    logic [WORD_BITS-1:0] sr_b_q;

    // tap[0] is the live line; tap[k] is the line k cycles ago. The strobe
    // arrives L cycles late, so tap[L - delay] is the line delay cycles after
    // the original strobe.
    assign tap    = {hist_q, miso_i};
    assign dly_c  = (int'(delay_i) > L) ? DELAY_W'(L) : delay_i;
    assign sel    = DELAY_W'(L) - dly_c;
    assign sample = tap[sel];

    assign nxt_a_o = shift_a_i ? {sr_a_q[WORD_BITS-2:0], sample} : sr_a_q;
    assign nxt_b_o = shift_b_i ? {sr_b_q[WORD_BITS-2:0], sample} : sr_b_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            sr_a_q <= '0;
            sr_b_q <= '0;
        end else begin
            hist_q <= tap[L-1:0];
            sr_a_q <= clear_i ? '0 : nxt_a_o;
            sr_b_q <= clear_i ? '0 : nxt_b_o;
        end
    end

endmodule

// File: rtl/rhd_miso_capture.sv
// rhd_miso_capture
//   Multi-port MISO capture engine. Delays the SPI strobes by a fixed L =
//   MAX_DELAY-1 cycles, lets each port pick its own sample point from its
//   history, and assembles WORD_BITS-bit words (plus a falling-edge word in
//   DDR mode) for all ports in parallel.
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     frame_start_i           CS-fall pulse; samples ddr_en_i and channel_in_i
//     sclk_rise_i/sclk_fall_i SCLK edge pulses from the SPI master
//     delay_i                 per-port delay, port p at [p*DELAY_W +: DELAY_W]
//     miso_i                  synchronised MISO lines
//     word_valid_o            one-cycle pulse with word_a_o/word_b_o/channel_out_o
//     overrun_o               one-cycle pulse: an incomplete frame was discarded
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame in progress, strobes ignored
//   RISE  | waiting for the next aligned SCLK rise (sr_a bit)
//   FALL  | DDR only: waiting for the aligned SCLK fall (sr_b bit)
module rhd_miso_capture
    import rhd_pkg::*;
#(
    parameter int N_PORTS   = 32,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DELAY_W   = $clog2(MAX_DELAY)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           frame_start_i,
    input  logic                           sclk_rise_i,
    input  logic                           sclk_fall_i,
    input  logic                           ddr_en_i,
    input  logic [CHANNEL_W-1:0]           channel_in_i,
    input  logic [N_PORTS*DELAY_W-1:0]     delay_i,
    input  logic [N_PORTS-1:0]             miso_i,
    output logic                           word_valid_o,
    output logic [N_PORTS*WORD_BITS-1:0]   word_a_o,
    output logic [N_PORTS*WORD_BITS-1:0]   word_b_o,
    output logic [CHANNEL_W-1:0]           channel_out_o,
    output logic                           overrun_o
);

    localparam int L     = MAX_DELAY - 1;
    localparam int CNT_W = $clog2(WORD_BITS);

    strobe_t pipe_in;
    strobe_t pipe_q [L];
    strobe_t d;

    state_e                         state_q;
    logic [CNT_W-1:0]               bit_cnt_q;
    logic                           ddr_lat_q;
    logic [CHANNEL_W-1:0]           chan_lat_q;
    logic                           word_valid_q;
    logic                           overrun_q;
    logic [N_PORTS*WORD_BITS-1:0]   word_a_q;
    logic [N_PORTS*WORD_BITS-1:0]   word_b_q;
    logic [CHANNEL_W-1:0]           channel_q;

    logic                           last_bit;
    logic                           shift_a;
    logic                           shift_b;
    logic                           done;
    logic [N_PORTS*WORD_BITS-1:0]   nxt_a;
    logic [N_PORTS*WORD_BITS-1:0]   nxt_b;

    assign pipe_in = {frame_start_i, sclk_rise_i, sclk_fall_i, ddr_en_i, channel_in_i};
    assign d       = pipe_q[L-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < L; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // A frame restart normally drops a coincident strobe, except when that
    // strobe is the final one of the running word: back-to-back frames put
    // the next frame_start on exactly that cycle, and the word must survive.
    always_comb begin
        last_bit = (bit_cnt_q == CNT_W'(WORD_BITS - 1));
        shift_a  = (state_q == ST_RISE) && d.rise && (!d.frame || (!ddr_lat_q && last_bit));
        shift_b  = (state_q == ST_FALL) && d.fall && (!d.frame || last_bit);
        done     = (shift_a && !ddr_lat_q && last_bit) || (shift_b && last_bit);
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        rhd_miso_port #(
            .MAX_DELAY (MAX_DELAY),
            .DELAY_W   (DELAY_W)
        ) u_port (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .miso_i    (miso_i[p]),
            .delay_i   (delay_i[p*DELAY_W +: DELAY_W]),
            .shift_a_i (shift_a),
            .shift_b_i (shift_b),
            .clear_i   (d.frame),
            .nxt_a_o   (nxt_a[p*WORD_BITS +: WORD_BITS]),
            .nxt_b_o   (nxt_b[p*WORD_BITS +: WORD_BITS])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            ddr_lat_q    <= 1'b0;
            chan_lat_q   <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            word_a_q     <= '0;
            word_b_q     <= '0;
            channel_q    <= '0;
        end else begin
            word_valid_q <= done;
            overrun_q    <= 1'b0;
            if (done) begin
                word_a_q  <= nxt_a;
                word_b_q  <= ddr_lat_q ? nxt_b : '0;
                channel_q <= chan_lat_q;
            end
            if (d.frame) begin
                overrun_q  <= (state_q != ST_IDLE) && !done;
                state_q    <= ST_RISE;
                bit_cnt_q  <= '0;
                ddr_lat_q  <= d.ddr;
                chan_lat_q <= d.chan;
            end else begin
                case (state_q)
                    ST_RISE: begin
                        if (shift_a) begin
                            if (ddr_lat_q)     state_q <= ST_FALL;
                            else if (last_bit) state_q <= ST_IDLE;
                            else               bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    ST_FALL: begin
                        if (shift_b) begin
                            if (last_bit) begin
                                state_q <= ST_IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                state_q   <= ST_RISE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign word_valid_o  = word_valid_q;
    assign overrun_o     = overrun_q;
    assign word_a_o      = word_a_q;
    assign word_b_o      = word_b_q;
    assign channel_out_o = channel_q;

endmodule
